ifu: RTL and testbench

Instruction fetch unit for the NPC core. It sits directly upstream of the decode stage. It owns the PC, issues one instruction-memory read at a time over a valid/ready request plus valid-only response interface, and presents each fetched word with its PC to decode through a registered valid/ready output. It accepts redirects (jumps, taken branches) from execute and a halt request (ebreak).

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu.sv | 123 ++++++++++++
 tb/tb_ifu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the NPC core front end: fetch state encoding,
// reset PC, instruction width and sequential PC increment.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_OUT  = 2'b10,
        S_DROP = 2'b11
    } ifu_state_e;

    localparam logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000;
    localparam int unsigned INST_WIDTH = 32;
    localparam logic [63:0] PC_STEP    = 64'd4;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight and
// hands each fetched word plus its PC to decode through a registered slot.
module ifu #(
    parameter int                XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(ifu_pkg::RESET_PC)
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic                           io_imem_req_valid,
    input  logic                           io_imem_req_ready,
    output logic [XLEN-1:0]                io_imem_req_addr,
    input  logic                           io_imem_resp_valid,
    input  logic [ifu_pkg::INST_WIDTH-1:0] io_imem_resp_data,
    output logic                           io_out_valid,
    input  logic                           io_out_ready,
    output logic [XLEN-1:0]                io_out_pc,
    output logic [ifu_pkg::INST_WIDTH-1:0] io_out_inst,
    input  logic                           io_redirect_valid,
    input  logic [XLEN-1:0]                io_redirect_pc,
    input  logic                           io_halt
);
    import ifu_pkg::*;

    ifu_state_e              state_q,     state_d;
    logic [XLEN-1:0]         pc_q,        pc_d;
    logic                    out_valid_q, out_valid_d;
    logic [XLEN-1:0]         out_pc_q,    out_pc_d;
    logic [INST_WIDTH-1:0]   out_inst_q,  out_inst_d;

    logic                    req_valid_s;
    logic                    req_fire_s;
    logic [XLEN-1:0]         redirect_target_s;
    logic                    redirect_lsb_unused_s;

    // Request decode: only S_REQ issues, and halt or reset suppress it.
    assign req_valid_s       = (state_q == S_REQ) && !io_halt && !reset;
    assign req_fire_s        = req_valid_s && io_imem_req_ready;
    assign redirect_target_s = {io_redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused_s = ^io_redirect_pc[1:0];

    assign io_imem_req_valid = req_valid_s;
    assign io_imem_req_addr  = pc_q;
    assign io_out_valid      = out_valid_q;
    assign io_out_pc         = out_pc_q;
    assign io_out_inst       = out_inst_q;

    // Next-state logic for FSM, PC and the decode-facing output slot.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;

        if (io_redirect_valid) begin
            // A redirect wins; an in-flight read must be drained in S_DROP.
            pc_d        = redirect_target_s;
            out_valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = req_fire_s ? S_DROP : S_REQ;
                S_WAIT:  state_d = io_imem_resp_valid ? S_REQ : S_DROP;
                S_OUT:   state_d = S_REQ;
                S_DROP:  state_d = S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (io_imem_resp_valid) begin
                        out_inst_d  = io_imem_resp_data;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + XLEN'(PC_STEP);
                        state_d     = S_OUT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_OUT: begin
                    if (out_valid_q && io_out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_REQ;
                    end else begin
                        state_d = S_OUT;
                    end
                end
                S_DROP: begin
                    if (io_imem_resp_valid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= {XLEN{1'b0}};
            out_inst_q  <= {INST_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu: reset, fetch, stall, redirects,
// halt and asynchronous reset, with hand-computed expected values.
module tb_ifu;

    logic        clock;
    logic        reset;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic [63:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [63:0] io_out_pc;
    logic [31:0] io_out_inst;
    logic        io_redirect_valid;
    logic [63:0] io_redirect_pc;
    logic        io_halt;

    int checks;
    int failures;

    ifu dut (
        .clock              (clock),
        .reset              (reset),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_out_valid       (io_out_valid),
        .io_out_ready       (io_out_ready),
        .io_out_pc          (io_out_pc),
        .io_out_inst        (io_out_inst),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_pc     (io_redirect_pc),
        .io_halt            (io_halt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_imem_req_ready = 1'b1;
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = 32'h0;
        io_out_ready = 1'b1;
        io_redirect_valid = 1'b0;
        io_redirect_pc = 64'h0;
        io_halt = 1'b0;
        step();
        step();
        checks++; if (io_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", io_out_valid); end
        checks++; if (io_out_pc !== 64'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", io_out_pc); end
        checks++; if (io_out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", io_out_inst); end
        checks++; if (io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", io_imem_req_valid); end
        reset = 1'b0;
        #1;
        checks++; if (io_imem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%0b exp=1", io_imem_req_valid); end
        checks++; if (io_imem_req_addr !== 64'h80000000) begin failures++; $display("FAIL first_req_addr got=%h exp=80000000", io_imem_req_addr); end
    endtask

    task automatic test_first_fetch();
        step();
        io_imem_req_ready = 1'b0;
        checks++; if (io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL wait_req_valid got=%0b exp=0", io_imem_req_valid); end
        checks++; if (io_out_valid !== 1'b0) begin failures++; $display("FAIL wait_out_valid got=%0b exp=0", io_out_valid); end
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'h00000413;
        step();
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = 32'h0;
        checks++; if (io_out_valid !== 1'b1) begin failures++; $display("FAIL fetch_out_valid got=%0b exp=1", io_out_valid); end
        checks++; if (io_out_pc !== 64'h80000000) begin failures++; $display("FAIL fetch_out_pc got=%h exp=80000000", io_out_pc); end
        checks++; if (io_out_inst !== 32'h00000413) begin failures++; $display("FAIL fetch_out_inst got=%h exp=00000413", io_out_inst); end
        checks++; if (io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL out_req_valid got=%0b exp=0", io_imem_req_valid); end
        io_imem_req_ready = 1'b1;
        step();
        checks++; if (io_out_valid !== 1'b0) begin failures++; $display("FAIL consumed_out_valid got=%0b exp=0", io_out_valid); end
        checks++; if (io_imem_req_addr !== 64'h80000004) begin failures++; $display("FAIL next_req_addr got=%h exp=80000004", io_imem_req_addr); end
        checks++; if (io_imem_req_valid !== 1'b1) begin failures++; $display("FAIL next_req_valid got=%0b exp=1", io_imem_req_valid); end
    endtask

    task automatic test_decode_stall();
        io_out_ready = 1'b0;
        step();
        io_imem_req_ready = 1'b0;
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'h00100093;
        step();
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = 32'h0;
        io_imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (io_out_valid !== 1'b1 || io_out_pc !== 64'h80000004 || io_out_inst !== 32'h00100093)
                begin failures++; $display("FAIL stall_hold cyc=%0d got=%0b/%h/%h exp=1/80000004/00100093", i, io_out_valid, io_out_pc, io_out_inst); end
            checks++; if (io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid cyc=%0d got=%0b exp=0", i, io_imem_req_valid); end
            step();
        end
        io_out_ready = 1'b1;
        step();
        checks++; if (io_imem_req_valid !== 1'b1) begin failures++; $display("FAIL stall_resume_valid got=%0b exp=1", io_imem_req_valid); end
        checks++; if (io_imem_req_addr !== 64'h80000008) begin failures++; $display("FAIL stall_resume_addr got=%h exp=80000008", io_imem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        step();
        io_imem_req_ready = 1'b0;
        io_redirect_valid = 1'b1;
        io_redirect_pc = 64'h80000103;
        step();
        io_redirect_valid = 1'b0;
        io_redirect_pc = 64'h0;
        checks++; if (io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL drop_req_valid got=%0b exp=0", io_imem_req_valid); end
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'hdeadbeef;
        step();
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = 32'h0;
        checks++; if (io_out_valid !== 1'b0) begin failures++; $display("FAIL drop_out_valid got=%0b exp=0", io_out_valid); end
        checks++; if (io_imem_req_valid !== 1'b1) begin failures++; $display("FAIL redir_req_valid got=%0b exp=1", io_imem_req_valid); end
        checks++; if (io_imem_req_addr !== 64'h80000100) begin failures++; $display("FAIL redir_req_addr got=%h exp=80000100", io_imem_req_addr); end
    endtask

    task automatic test_redirect_resp();
        io_imem_req_ready = 1'b1;
        step();
        io_imem_req_ready = 1'b0;
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'hcafef00d;
        io_redirect_valid = 1'b1;
        io_redirect_pc = 64'h80000202;
        step();
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = 32'h0;
        io_redirect_valid = 1'b0;
        io_redirect_pc = 64'h0;
        checks++; if (io_out_valid !== 1'b0) begin failures++; $display("FAIL coin_out_valid got=%0b exp=0", io_out_valid); end
        checks++; if (io_imem_req_valid !== 1'b1) begin failures++; $display("FAIL coin_req_valid got=%0b exp=1", io_imem_req_valid); end
        checks++; if (io_imem_req_addr !== 64'h80000200) begin failures++; $display("FAIL coin_req_addr got=%h exp=80000200", io_imem_req_addr); end
    endtask

    task automatic test_halt();
        io_imem_req_ready = 1'b1;
        step();
        io_imem_req_ready = 1'b0;
        io_halt = 1'b1;
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'h00000013;
        step();
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = 32'h0;
        checks++; if (io_out_valid !== 1'b1 || io_out_pc !== 64'h80000200 || io_out_inst !== 32'h00000013)
            begin failures++; $display("FAIL halt_deliver got=%0b/%h/%h exp=1/80000200/00000013", io_out_valid, io_out_pc, io_out_inst); end
        io_imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL halt_req_valid cyc=%0d got=%0b exp=0", i, io_imem_req_valid); end
        end
        io_halt = 1'b0;
        #1;
        checks++; if (io_imem_req_valid !== 1'b1) begin failures++; $display("FAIL unhalt_req_valid got=%0b exp=1", io_imem_req_valid); end
        checks++; if (io_imem_req_addr !== 64'h80000204) begin failures++; $display("FAIL unhalt_req_addr got=%h exp=80000204", io_imem_req_addr); end
    endtask

    task automatic test_async_reset();
        step();
        io_imem_req_ready = 1'b0;
        io_out_ready = 1'b0;
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'h00200113;
        step();
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = 32'h0;
        checks++; if (io_out_valid !== 1'b1 || io_out_pc !== 64'h80000204)
            begin failures++; $display("FAIL pre_reset_out got=%0b/%h exp=1/80000204", io_out_valid, io_out_pc); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (io_out_valid !== 1'b0) begin failures++; $display("FAIL async_out_valid got=%0b exp=0", io_out_valid); end
        checks++; if (io_out_pc !== 64'h0 || io_out_inst !== 32'h0) begin failures++; $display("FAIL async_out_regs got=%h/%h exp=0/0", io_out_pc, io_out_inst); end
        checks++; if (io_imem_req_addr !== 64'h80000000) begin failures++; $display("FAIL async_pc got=%h exp=80000000", io_imem_req_addr); end
        checks++; if (io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL async_req_valid got=%0b exp=0", io_imem_req_valid); end
        step();
        reset = 1'b0;
        io_out_ready = 1'b1;
        #1;
        checks++; if (io_imem_req_valid !== 1'b1 || io_imem_req_addr !== 64'h80000000)
            begin failures++; $display("FAIL post_reset_req got=%0b/%h exp=1/80000000", io_imem_req_valid, io_imem_req_addr); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_first_fetch();
        test_decode_stall();
        test_redirect_wait();
        test_redirect_resp();
        test_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
